onchip_memory_dma_master: RTL and testbench
===========================================

Name: onchip_memory_dma_master

Overview:
- Avalon-MM master that drives the single-port on-chip memory slave (32-bit data, 14-bit word address, 12288 words, read latency 1, no waitrequest).
- Executes one command at a time: block copy, block fill, or checksum read-back over a word range.
- Sits between a control/CSR block and the memory's s1 port.
- Used for buffer initialisation and memory self-test.

Parameters:
- DEPTH, 12288, number of valid words in the target memory; ranges exceeding it are rejected.
- ADDR_W, 14, word-address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  command strobe; sampled only when busy=0
- mode  in  2  0=copy, 1=fill, 2=checksum, 3=reserved (rejected)
- src_addr  in  14  first source word (copy, checksum)
- dst_addr  in  14  first destination word (copy, fill)
- length  in  15  word count, 0..DEPTH
- fill_data  in  32  pattern for fill
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- error  out  1  valid with done; command rejected
- checksum  out  32  sum of words read by the last command
- avm_address  out  14  memory address
- avm_chipselect  out  1  access strobe
- avm_write  out  1  1=write, 0=read when chipselect=1
- avm_byteenable  out  4  constant 4'b1111
- avm_writedata  out  32  write data
- avm_readdata  in  32  valid the cycle after a read is issued
- avm_clken  out  1  constant 1

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - busy, done, error, avm_chipselect and avm_write clear to 0; avm_address, avm_writedata and checksum clear to 0.
  - State returns to IDLE. Any in-flight command is abandoned, with no done pulse.
- States: IDLE, RD, CAP, WR, FILL, SUM, FIN.
- IDLE:
  - start=1 latches all command inputs, clears checksum, and sets busy at the same edge.
  - Rejected commands go to FIN with error=1 and make no bus access. A command is rejected if mode=3, or length>DEPTH, or the used range overruns: (src_addr+length)>DEPTH for copy/checksum, (dst_addr+length)>DEPTH for copy/fill. Range checks use 15-bit arithmetic, so there is no wrap.
  - length=0 goes to FIN with error=0 and makes no bus access.
- Start handling: start while busy=1 is ignored, with no queuing.
- Copy (3 cycles per word), word index i from 0 to length-1:
  - RD: chipselect=1, write=0, address=src+i.
  - CAP: chipselect=0; avm_readdata is registered into the data buffer and added to checksum.
  - WR: chipselect=1, write=1, address=dst+i, writedata=buffer.
  - After the last WR, go to FIN. Total bus phase is 3*length cycles.
  - Overlapping ranges are copied in ascending order. With dst>src and overlap, the source is overwritten before it is read; this is intended and documented, not corrected.
- Fill (1 cycle per word): FILL issues a write to dst+i with fill_data every cycle for length cycles, then goes to FIN. checksum stays 0.
- Checksum (pipelined):
  - SUM issues reads of src+i on consecutive cycles (length cycles).
  - Each cycle after an issued read, avm_readdata is added to checksum, including one drain cycle after the last issue with chipselect=0.
  - Bus phase is length+1 cycles.
- FIN: done=1 for exactly one cycle, busy=0 in that cycle, chipselect=0. Return to IDLE next edge. error is meaningful only while done=1; otherwise it is 0.
- checksum arithmetic: modulo 2^32 sum. It holds its value until the next accepted start.
- Bus rules:
  - avm_write=0 whenever avm_chipselect=0.
  - A read and a write are never issued in the same cycle.
  - Addresses never exceed DEPTH-1.
- Outputs: all outputs are registered except the constants avm_byteenable and avm_clken.

Test Plan:
- Reset mid-copy: assert reset_n=0 at the 5th bus cycle of a copy of length 8 -> next cycle busy=0, chipselect=0, no done. A subsequent start is accepted normally.
- Fill: dst=0x0100, length=4, fill_data=0xA5A5_0001 -> 4 consecutive write cycles to 0x0100..0x0103. done on the 5th cycle after start. Memory words read back equal 0xA5A5_0001.
- Copy: preload words 0x0000..0x0002 with 1, 2, 0xFFFF_FFFF; copy src=0, dst=0x0200, length=3 -> 9 bus cycles, then done with error=0. Destination holds 1, 2, 0xFFFF_FFFF. checksum=0x0000_0002 (wrap).
- Checksum: preload 0x2FFE=0x1000_0000 and 0x2FFF=0x2000_0000; checksum src=0x2FFE, length=2 -> reads on 2 consecutive cycles, done 3 cycles after the first read, checksum=0x3000_0000.
- Rejection: fill dst=0x2FFF, length=2 (sum 12289>12288); also mode=3 -> no chipselect at all, done with error=1 one cycle after start.
- Boundary and ignore: length=0 copy -> done with error=0, no bus access. start pulsed while busy during a fill of length 10 -> ignored, exactly 10 writes, one done.

Source files
------------

// File: rtl/onchip_memory_dma_master.sv
// onchip_memory_dma_master: Avalon-MM master for block copy, fill and checksum on on-chip RAM
module onchip_memory_dma_master #(
  parameter int DEPTH  = 12288,
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W:0]     length,
  input  logic [DATA_W-1:0]   fill_data,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [DATA_W-1:0]   checksum,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic                avm_clken
);
  localparam logic [2:0] S_IDLE = 3'd0, S_RD = 3'd1, S_CAP = 3'd2, S_WR = 3'd3,
                         S_FILL = 3'd4, S_SUM = 3'd5, S_FIN = 3'd6;
  localparam logic [ADDR_W:0] lim = (ADDR_W+1)'(DEPTH);
  logic [2:0]        state;
  logic [ADDR_W-1:0] src, dst;
  logic [ADDR_W:0]   len, idx, idx_n, src_end, dst_end;
  logic              pend, reject;
  function automatic logic [ADDR_W-1:0] at(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] i);
    return ADDR_W'({1'b0, b} + i);
  endfunction
  assign avm_byteenable = '1;
  assign avm_clken      = 1'b1;
  assign idx_n          = idx + 1'b1;
  assign src_end        = {1'b0, src_addr} + length;
  assign dst_end        = {1'b0, dst_addr} + length;
  assign reject = mode == 2'd3 || length > lim ||
                  (mode != 2'd1 && src_end > lim) || (mode != 2'd2 && dst_end > lim);
  // Command sequencer: every bus output is registered and set for the cycle that follows the edge;
  // pend marks the cycle in which read data from the previous cycle's read is on avm_readdata.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      error          <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_write      <= 1'b0;
      avm_address    <= '0;
      avm_writedata  <= '0;
      checksum       <= '0;
      pend           <= 1'b0;
      src            <= '0;
      dst            <= '0;
      len            <= '0;
      idx            <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      pend  <= avm_chipselect & ~avm_write;
      if (pend) checksum <= checksum + avm_readdata;
      case (state)
        S_IDLE: if (start) begin
          src      <= src_addr;
          dst      <= dst_addr;
          len      <= length;
          checksum <= '0;
          if (reject || length == '0) begin
            state <= S_FIN;
            done  <= 1'b1;
            error <= reject;
          end else begin
            busy           <= 1'b1;
            avm_chipselect <= 1'b1;
            avm_write      <= mode == 2'd1;
            avm_address    <= mode == 2'd1 ? dst_addr : src_addr;
            avm_writedata  <= fill_data;
            idx            <= mode == 2'd0 ? '0 : (ADDR_W+1)'(1);
            state          <= mode == 2'd0 ? S_RD : mode == 2'd1 ? S_FILL : S_SUM;
          end
        end
        S_RD: begin
          avm_chipselect <= 1'b0;
          state          <= S_CAP;
        end
        S_CAP: begin
          avm_chipselect <= 1'b1;
          avm_write      <= 1'b1;
          avm_address    <= at(dst, idx);
          avm_writedata  <= avm_readdata;
          state          <= S_WR;
        end
        S_WR: if (idx_n == len) begin
          state          <= S_FIN;
          busy           <= 1'b0;
          done           <= 1'b1;
          avm_chipselect <= 1'b0;
          avm_write      <= 1'b0;
        end else begin
          avm_write   <= 1'b0;
          avm_address <= at(src, idx_n);
          idx         <= idx_n;
          state       <= S_RD;
        end
        S_FILL: if (idx == len) begin
          state          <= S_FIN;
          busy           <= 1'b0;
          done           <= 1'b1;
          avm_chipselect <= 1'b0;
          avm_write      <= 1'b0;
        end else begin
          avm_address <= at(dst, idx);
          idx         <= idx_n;
        end
        S_SUM: if (!avm_chipselect) begin
          state <= S_FIN;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else if (idx == len) begin
          avm_chipselect <= 1'b0;
        end else begin
          avm_address <= at(src, idx);
          idx         <= idx_n;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_onchip_memory_dma_master.sv
// tb_onchip_memory_dma_master: randomized check of the DMA master against a word-level reference model
module tb_onchip_memory_dma_master;
  localparam int DEPTH = 12288;
  typedef struct packed {logic cs; logic we; logic [13:0] a; logic [31:0] d;} bus_t;
  logic clk = 0, reset_n = 0, start = 0;
  logic [1:0] mode = 0;
  logic [13:0] src_addr = 0, dst_addr = 0;
  logic [14:0] length = 0;
  logic [31:0] fill_data = 0;
  logic busy, done, error, avm_chipselect, avm_write, avm_clken;
  logic [31:0] checksum, avm_writedata, avm_readdata;
  logic [13:0] avm_address;
  logic [3:0] avm_byteenable;
  logic [31:0] mem [0:16383];
  logic [31:0] ref_mem [0:DEPTH-1];
  bus_t exp_q[$], got_q[$];
  int n_chk = 0, n_fail = 0, exp_lat;
  logic exp_err;
  logic [31:0] exp_sum;

  onchip_memory_dma_master dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode), .src_addr(src_addr),
    .dst_addr(dst_addr), .length(length), .fill_data(fill_data), .busy(busy), .done(done),
    .error(error), .checksum(checksum), .avm_address(avm_address),
    .avm_chipselect(avm_chipselect), .avm_write(avm_write), .avm_byteenable(avm_byteenable),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .avm_clken(avm_clken));

  always #5 clk = ~clk;

  // on-chip memory slave: read latency 1, no waitrequest
  always @(posedge clk) begin
    if (avm_chipselect && avm_write) mem[avm_address] <= avm_writedata;
    avm_readdata <= mem[avm_address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // word-level reference: expected bus cycles, completion latency, error and checksum
  task automatic model(input int m, input int s, input int d, input int l, input logic [31:0] f);
    logic [31:0] v;
    exp_q.delete();
    exp_sum = 0;
    exp_err = m == 3 || l > DEPTH || (m != 1 && s + l > DEPTH) || (m != 2 && d + l > DEPTH);
    exp_lat = 1;
    if (exp_err || l == 0) return;
    for (int i = 0; i < l; i++) begin
      if (m == 0) begin
        v = ref_mem[s+i];
        exp_sum += v;
        exp_q.push_back({1'b1, 1'b0, 14'(s+i), 32'h0});
        exp_q.push_back({1'b0, 1'b0, 14'h0, 32'h0});
        exp_q.push_back({1'b1, 1'b1, 14'(d+i), v});
        ref_mem[d+i] = v;
      end else if (m == 1) begin
        exp_q.push_back({1'b1, 1'b1, 14'(d+i), f});
        ref_mem[d+i] = f;
      end else begin
        exp_sum += ref_mem[s+i];
        exp_q.push_back({1'b1, 1'b0, 14'(s+i), 32'h0});
      end
    end
    if (m == 2) exp_q.push_back({1'b0, 1'b0, 14'h0, 32'h0});
    exp_lat = m == 0 ? 3*l + 1 : m == 1 ? l + 1 : l + 2;
  endtask

  task automatic run(input int m, input int s, input int d, input int l, input logic [31:0] f, input bit poke);
    int got_lat, bad, rule, extra;
    bus_t e, o;
    model(m, s, d, l, f);
    got_q.delete();
    got_lat = -1;
    @(negedge clk);
    start = 1; mode = 2'(m); src_addr = 14'(s); dst_addr = 14'(d); length = 15'(l); fill_data = f;
    @(posedge clk);
    #1 start = 0;
    for (int n = 1; n <= exp_lat + 20; n++) begin
      @(negedge clk);
      if (poke && n == 3) begin
        start = 1; mode = 2'd1; dst_addr = 14'h0; length = 15'd5; fill_data = 32'hDEADBEEF;
      end
      if (poke && n == 4) start = 0;
      if (done) begin
        got_lat = n;
        break;
      end
      got_q.push_back({avm_chipselect, avm_write, avm_address, avm_writedata});
    end
    check("latency", got_lat, exp_lat);
    if (got_lat > 0) begin
      check("error", error, exp_err);
      check("busy_at_done", busy, 0);
      check("cs_at_done", avm_chipselect, 0);
    end
    check("checksum", checksum, exp_sum);
    check("bus_len", got_q.size(), exp_q.size());
    bad = 0;
    rule = 0;
    for (int k = 0; k < got_q.size(); k++) begin
      o = got_q[k];
      if ((o.we && !o.cs) || (o.cs && o.a >= DEPTH)) rule++;
      if (k < exp_q.size()) begin
        e = exp_q[k];
        if (o.cs !== e.cs || o.we !== e.we || (e.cs && o.a !== e.a) || (e.we && o.d !== e.d)) bad++;
      end
    end
    check("bus_seq", bad, 0);
    check("bus_rules", rule, 0);
    if (poke) begin
      extra = 0;
      repeat (8) begin
        @(negedge clk);
        if (done || avm_chipselect) extra++;
      end
      check("ignored_start", extra, 0);
    end
  endtask

  initial begin
    int cnt, m, s, d, l;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_cs", avm_chipselect, 0);
    check("rst_we", avm_write, 0);
    check("rst_addr", avm_address, 0);
    check("rst_wdata", avm_writedata, 0);
    check("rst_sum", checksum, 0);
    check("byteenable", avm_byteenable, 4'hF);
    check("clken", avm_clken, 1);
    reset_n = 1;
    run(1, 0, 0, DEPTH, 32'h1234_5678, 0);
    run(1, 0, 16'h0100, 4, 32'hA5A5_0001, 0);
    run(2, 16'h0100, 0, 4, 0, 0);
    run(1, 0, 0, 1, 32'h1, 0);
    run(1, 0, 1, 1, 32'h2, 0);
    run(1, 0, 2, 1, 32'hFFFF_FFFF, 0);
    run(0, 0, 16'h0200, 3, 0, 0);
    check("copy_sum_wrap", checksum, 32'h2);
    run(1, 0, 16'h2FFE, 1, 32'h1000_0000, 0);
    run(1, 0, 16'h2FFF, 1, 32'h2000_0000, 0);
    run(2, 16'h2FFE, 0, 2, 0, 0);
    check("sum_top", checksum, 32'h3000_0000);
    run(1, 0, 16'h2FFF, 2, 32'h5, 0);
    run(3, 0, 0, 1, 0, 0);
    run(1, 0, 0, DEPTH + 1, 32'h7, 0);
    run(2, 16'h2FFF, 0, 2, 0, 0);
    run(0, 0, 16'h2FFF, 2, 0, 0);
    run(0, 5, 6, 0, 0, 0);
    run(1, 0, 16'h0300, 10, 32'hCAFE_0010, 1);
    run(0, 16'h0300, 16'h0302, 6, 0, 0);
    // reset during the 5th bus cycle of an 8-word copy
    @(negedge clk);
    start = 1; mode = 0; src_addr = 14'h10; dst_addr = 14'h40; length = 15'd8;
    @(posedge clk);
    #1 start = 0;
    repeat (5) @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    check("rstmid_busy", busy, 0);
    check("rstmid_cs", avm_chipselect, 0);
    check("rstmid_done", done, 0);
    check("rstmid_sum", checksum, 0);
    reset_n = 1;
    ref_mem[14'h40] = ref_mem[14'h10];
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    check("rstmid_quiet", cnt, 0);
    run(2, 16'h40, 0, 2, 0, 0);
    for (int t = 0; t < 40; t++) begin
      m = $urandom_range(0, 3);
      l = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 20);
      s = $urandom_range(0, 3) == 0 ? DEPTH - $urandom_range(0, 24) : $urandom_range(0, 16383);
      d = $urandom_range(0, 3) == 0 ? DEPTH - $urandom_range(0, 24) : $urandom_range(0, 16383);
      if ($urandom_range(0, 2) == 0) d = s + $urandom_range(0, 4);
      run(m, s, d, l, $urandom, 0);
    end
    cnt = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) cnt++;
    check("mem_image", cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
